cpu_mem_arbiter: RTL and testbench

Downstream companion to the CPU wrapper: merges the core's instruction bus (iBus) and data bus (dBus) onto one single-ported memory port (iCE40 SPRAM/BRAM controller). Fixed-priority arbitration (dBus over iBus), one outstanding read at a time, byte-mask generation from dBus size/address, and registered read responses routed back to the requesting bus.

---
 rtl/cpu_mem_arbiter_pkg.sv | 19 +
 rtl/cpu_mem_wmask.sv | 23 ++
 rtl/cpu_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and constants for the CPU iBus/dBus to single-port memory arbiter.
package cpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } arbState_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [3:0] MASK_FULL    = 4'b1111;
    localparam logic [3:0] MASK_LO_HALF = 4'b0011;
    localparam logic [3:0] MASK_HI_HALF = 4'b1100;
    localparam logic [3:0] MASK_BYTE0   = 4'b0001;

endpackage

// File: rtl/cpu_mem_wmask.sv
// Byte-lane enable generation from access size and the low byte-address bits.
module cpu_mem_wmask
    import cpu_mem_arbiter_pkg::*;
(
    input  logic       fullWord,
    input  logic [1:0] size,
    input  logic [1:0] addrLo,
    output logic [3:0] mask
);

    // Fetches and all reads take the whole word; size 3 falls into the word case.
    always_comb begin
        mask = MASK_FULL;
        if (!fullWord) begin
            case (size)
                SIZE_BYTE: mask = MASK_BYTE0 << addrLo;
                SIZE_HALF: mask = addrLo[1] ? MASK_HI_HALF : MASK_LO_HALF;
                default:   mask = MASK_FULL;
            endcase
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Merges iBus and dBus onto one memory port, dBus first, one read in flight.
// Optional out-of-range address trapping: CPU_MEM_ARB_ADDR_CHECK_EN.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int MEM_BYTES = 131072,
    parameter int WADDR_W   = $clog2(MEM_BYTES) - 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iBus_cmd_valid,
    output logic               iBus_cmd_ready,
    input  logic [31:0]        iBus_cmd_payload_pc,
    output logic               iBus_rsp_valid,
    output logic               iBus_rsp_payload_error,
    output logic [31:0]        iBus_rsp_payload_inst,
    input  logic               dBus_cmd_valid,
    output logic               dBus_cmd_ready,
    input  logic               dBus_cmd_payload_wr,
    input  logic [31:0]        dBus_cmd_payload_address,
    input  logic [31:0]        dBus_cmd_payload_data,
    input  logic [1:0]         dBus_cmd_payload_size,
    output logic               dBus_rsp_ready,
    output logic               dBus_rsp_error,
    output logic [31:0]        dBus_rsp_data,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic               mem_wr,
    output logic [WADDR_W-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_wmask,
    input  logic               mem_rvalid,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_err,
    output logic [1:0]         dbgState
);

    // Handshakes: a command moves when its cmd_valid and cmd_ready are both high
    // in the same cycle; the memory takes a request when mem_valid & mem_ready.
    // The requester holds valid and payload stable until ready is seen.

    arbState_t   state;
    logic        grantD;
    logic        grantI;
    logic        grantAny;
    logic        isWrite;
    logic        outOfRange;
    logic        accept;
    logic        xfer;
    logic [31:0] selAddr;
    logic [3:0]  selMask;
    logic        unusedAddrBits;

    always_comb begin
        grantD   = (state == IDLE) && dBus_cmd_valid;
        grantI   = (state == IDLE) && !dBus_cmd_valid && iBus_cmd_valid;
        grantAny = grantD || grantI;
        isWrite  = grantD && dBus_cmd_payload_wr;
        selAddr  = 32'd0;
        if (grantD)
            selAddr = dBus_cmd_payload_address;
        else if (grantI)
            selAddr = iBus_cmd_payload_pc;
    end

`ifdef CPU_MEM_ARB_ADDR_CHECK_EN
    assign outOfRange = grantAny && ({1'b0, selAddr} >= 33'(MEM_BYTES));
`else
    assign outOfRange = 1'b0;
`endif

    // Only consumed when the address check is built in; otherwise memory aliases.
    assign unusedAddrBits = ^selAddr[31:WADDR_W+2];

    cpu_mem_wmask uWmask (
        .fullWord (!isWrite),
        .size     (dBus_cmd_payload_size),
        .addrLo   (selAddr[1:0]),
        .mask     (selMask)
    );

    assign mem_valid = grantAny && !outOfRange;
    assign mem_wr    = isWrite && !outOfRange;
    assign mem_addr  = selAddr[WADDR_W+1:2];
    assign mem_wdata = grantD ? dBus_cmd_payload_data : 32'd0;
    assign mem_wmask = grantAny ? selMask : 4'd0;
    assign xfer      = mem_valid && mem_ready;

    // Trapped requests never reach memory, so they complete without mem_ready.
    assign accept         = outOfRange || mem_ready;
    assign iBus_cmd_ready = grantI && accept;
    assign dBus_cmd_ready = grantD && accept;
    assign dbgState       = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= IDLE;
            iBus_rsp_valid         <= 1'b0;
            iBus_rsp_payload_error <= 1'b0;
            iBus_rsp_payload_inst  <= 32'd0;
            dBus_rsp_ready         <= 1'b0;
            dBus_rsp_error         <= 1'b0;
            dBus_rsp_data          <= 32'd0;
        end else begin
            iBus_rsp_valid <= 1'b0;
            dBus_rsp_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (outOfRange && !isWrite) begin
                        if (grantD) begin
                            dBus_rsp_ready <= 1'b1;
                            dBus_rsp_error <= 1'b1;
                            dBus_rsp_data  <= 32'd0;
                        end else begin
                            iBus_rsp_valid         <= 1'b1;
                            iBus_rsp_payload_error <= 1'b1;
                            iBus_rsp_payload_inst  <= 32'd0;
                        end
                    end else if (xfer && !isWrite) begin
                        state <= grantD ? WAIT_D : WAIT_I;
                    end
                end
                WAIT_I: begin
                    if (mem_rvalid) begin
                        iBus_rsp_valid         <= 1'b1;
                        iBus_rsp_payload_error <= mem_err;
                        iBus_rsp_payload_inst  <= mem_rdata;
                        state                  <= IDLE;
                    end
                end
                WAIT_D: begin
                    if (mem_rvalid) begin
                        dBus_rsp_ready <= 1'b1;
                        dBus_rsp_error <= mem_err;
                        dBus_rsp_data  <= mem_rdata;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: vector table, directed multi-cycle sequences, random traffic vs a memory model.
module tb_cpu_mem_arbiter;
    import cpu_mem_arbiter_pkg::*;

    localparam int WADDR_W = 15;

    logic               clk = 1'b0;
    logic               reset;
    logic               iBus_cmd_valid;
    logic               iBus_cmd_ready;
    logic [31:0]        iBus_cmd_payload_pc;
    logic               iBus_rsp_valid;
    logic               iBus_rsp_payload_error;
    logic [31:0]        iBus_rsp_payload_inst;
    logic               dBus_cmd_valid;
    logic               dBus_cmd_ready;
    logic               dBus_cmd_payload_wr;
    logic [31:0]        dBus_cmd_payload_address;
    logic [31:0]        dBus_cmd_payload_data;
    logic [1:0]         dBus_cmd_payload_size;
    logic               dBus_rsp_ready;
    logic               dBus_rsp_error;
    logic [31:0]        dBus_rsp_data;
    logic               mem_valid;
    logic               mem_ready;
    logic               mem_wr;
    logic [WADDR_W-1:0] mem_addr;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_wmask;
    logic               mem_rvalid;
    logic [31:0]        mem_rdata;
    logic               mem_err;
    logic [1:0]         dbgState;

    cpu_mem_arbiter dut (
        .clk                      (clk),
        .reset                    (reset),
        .iBus_cmd_valid           (iBus_cmd_valid),
        .iBus_cmd_ready           (iBus_cmd_ready),
        .iBus_cmd_payload_pc      (iBus_cmd_payload_pc),
        .iBus_rsp_valid           (iBus_rsp_valid),
        .iBus_rsp_payload_error   (iBus_rsp_payload_error),
        .iBus_rsp_payload_inst    (iBus_rsp_payload_inst),
        .dBus_cmd_valid           (dBus_cmd_valid),
        .dBus_cmd_ready           (dBus_cmd_ready),
        .dBus_cmd_payload_wr      (dBus_cmd_payload_wr),
        .dBus_cmd_payload_address (dBus_cmd_payload_address),
        .dBus_cmd_payload_data    (dBus_cmd_payload_data),
        .dBus_cmd_payload_size    (dBus_cmd_payload_size),
        .dBus_rsp_ready           (dBus_rsp_ready),
        .dBus_rsp_error           (dBus_rsp_error),
        .dBus_rsp_data            (dBus_rsp_data),
        .mem_valid                (mem_valid),
        .mem_ready                (mem_ready),
        .mem_wr                   (mem_wr),
        .mem_addr                 (mem_addr),
        .mem_wdata                (mem_wdata),
        .mem_wmask                (mem_wmask),
        .mem_rvalid               (mem_rvalid),
        .mem_rdata                (mem_rdata),
        .mem_err                  (mem_err),
        .dbgState                 (dbgState)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic idleInputs();
        iBus_cmd_valid           = 1'b0;
        iBus_cmd_payload_pc      = 32'd0;
        dBus_cmd_valid           = 1'b0;
        dBus_cmd_payload_wr      = 1'b0;
        dBus_cmd_payload_address = 32'd0;
        dBus_cmd_payload_data    = 32'd0;
        dBus_cmd_payload_size    = 2'd0;
        mem_ready                = 1'b0;
        mem_rvalid               = 1'b0;
        mem_rdata                = 32'd0;
        mem_err                  = 1'b0;
    endtask

    task automatic driveD(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size);
        dBus_cmd_valid           = 1'b1;
        dBus_cmd_payload_wr      = wr;
        dBus_cmd_payload_address = addr;
        dBus_cmd_payload_data    = data;
        dBus_cmd_payload_size    = size;
    endtask

    task automatic driveI(input logic [31:0] pc);
        iBus_cmd_valid      = 1'b1;
        iBus_cmd_payload_pc = pc;
    endtask

    // Reference rules
    function automatic logic [3:0] refMask(input logic wr, input logic [1:0] size, input logic [31:0] addr);
        if (!wr || size >= 2'd2) return 4'hF;
        if (size == 2'd1) return 4'(3 << (2 * addr[1]));
        return 4'(1 << addr[1:0]);
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (mask[b]) r[b*8 +: 8] = data[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] replicate(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
`ifndef CPU_MEM_ARB_ADDR_CHECK_EN
        a[18:17] = 2'($urandom_range(0, 3));
`endif
        return a;
    endfunction

    // Vector table
    typedef struct {
        logic        dV;
        logic        dWr;
        logic [31:0] dAddr;
        logic [31:0] dData;
        logic [1:0]  dSize;
        logic        iV;
        logic [31:0] pc;
        logic        mr;
        logic        mV;
        logic        mWr;
        logic [14:0] mAddr;
        logic [31:0] mWdata;
        logic [3:0]  mMask;
        logic        chkW;
        logic        iR;
        logic        dR;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic dV, input logic dWr, input logic [31:0] dAddr,
                          input logic [31:0] dData, input logic [1:0] dSize, input logic iV,
                          input logic [31:0] pc, input logic mr, input logic mV, input logic mWr,
                          input logic [14:0] mAddr, input logic [31:0] mWdata,
                          input logic [3:0] mMask, input logic chkW, input logic iR, input logic dR);
        vec_t v;
        v.dV = dV; v.dWr = dWr; v.dAddr = dAddr; v.dData = dData; v.dSize = dSize;
        v.iV = iV; v.pc = pc; v.mr = mr;
        v.mV = mV; v.mWr = mWr; v.mAddr = mAddr; v.mWdata = mWdata; v.mMask = mMask;
        v.chkW = chkW; v.iR = iR; v.dR = dR;
        vecs.push_back(v);
    endtask

    // Completes an accepted read and checks that the right bus gets the word back.
    task automatic finishRead(input logic isD, input int idx);
        logic [31:0] word;
        word = 32'hC0DE_0000 + 32'(idx);
        @(negedge clk);
        idleInputs();
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checkVal($sformatf("vec%0d_rsp_strobe", idx), {iBus_rsp_valid, dBus_rsp_ready}, isD ? 2'b01 : 2'b10);
        checkVal($sformatf("vec%0d_rsp_data", idx), isD ? dBus_rsp_data : iBus_rsp_payload_inst, word);
    endtask

    // Random-phase model state
    logic [31:0] devMem[16];
    logic [31:0] refMem[16];

    initial begin
        vec_t        v;
        logic        iPend, dPend, dWr, rvNow, gD, gI, strobeErr;
        logic [31:0] iPc, dAddr, dData, busyData, strobeData, expAddr;
        logic [1:0]  dSize;
        logic [3:0]  devWord;
        int          busyOwner, strobeOwner, rvLeft;

        reset = 1'b1;
        idleInputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("rst_outputs", {iBus_cmd_ready, dBus_cmd_ready, iBus_rsp_valid, iBus_rsp_payload_error,
                 dBus_rsp_ready, dBus_rsp_error, mem_valid, mem_wr}, 8'd0);
        checkVal("rst_rsp_data", {iBus_rsp_payload_inst, dBus_rsp_data}, 64'd0);
        checkVal("rst_payload", {mem_addr, mem_wdata, mem_wmask}, 64'd0);
        checkVal("rst_state", dbgState, IDLE);

        //     dV dWr dAddr          dData          sz iV pc        mr mV mWr mAddr    mWdata         mask  chkW iR dR
        addVec(0, 0, 32'h0,         32'h0,         0, 0, 32'h0,  1, 0, 0, 15'h0,  32'h0,         4'h0, 1, 0, 0);
        addVec(0, 0, 32'h0,         32'h0,         0, 1, 32'h10, 1, 1, 0, 15'h4,  32'h0,         4'hF, 0, 1, 0);
        addVec(1, 1, 32'h103,       32'hABABABAB,  0, 0, 32'h0,  1, 1, 1, 15'h40, 32'hABABABAB,  4'h8, 1, 0, 1);
        addVec(1, 1, 32'h102,       32'hCDEFCDEF,  1, 0, 32'h0,  1, 1, 1, 15'h40, 32'hCDEFCDEF,  4'hC, 1, 0, 1);
        addVec(1, 1, 32'h100,       32'h12341234,  1, 0, 32'h0,  1, 1, 1, 15'h40, 32'h12341234,  4'h3, 1, 0, 1);
        addVec(1, 1, 32'h101,       32'h5A5A5A5A,  0, 0, 32'h0,  1, 1, 1, 15'h40, 32'h5A5A5A5A,  4'h2, 1, 0, 1);
        addVec(1, 1, 32'h200,       32'hDEADBEEF,  2, 0, 32'h0,  1, 1, 1, 15'h80, 32'hDEADBEEF,  4'hF, 1, 0, 1);
        addVec(1, 1, 32'h204,       32'h01020304,  3, 0, 32'h0,  1, 1, 1, 15'h81, 32'h01020304,  4'hF, 1, 0, 1);
        addVec(1, 0, 32'h105,       32'h0,         0, 0, 32'h0,  0, 1, 0, 15'h41, 32'h0,         4'hF, 0, 0, 0);
        addVec(1, 1, 32'h8,         32'h11112222,  2, 1, 32'h20, 1, 1, 1, 15'h2,  32'h11112222,  4'hF, 1, 0, 1);
        addVec(1, 0, 32'h30,        32'h0,         1, 1, 32'h40, 0, 1, 0, 15'hC,  32'h0,         4'hF, 0, 0, 0);
        addVec(0, 0, 32'h0,         32'h0,         0, 1, 32'h7C, 0, 1, 0, 15'h1F, 32'h0,         4'hF, 0, 0, 0);
        addVec(1, 0, 32'h10,        32'h0,         2, 0, 32'h0,  1, 1, 0, 15'h4,  32'h0,         4'hF, 0, 0, 1);
`ifndef CPU_MEM_ARB_ADDR_CHECK_EN
        addVec(1, 1, 32'h0002_0006, 32'h77887788,  1, 0, 32'h0,  1, 1, 1, 15'h1,  32'h77887788,  4'hC, 1, 0, 1);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            idleInputs();
            if (v.dV) driveD(v.dWr, v.dAddr, v.dData, v.dSize);
            if (v.iV) driveI(v.pc);
            mem_ready = v.mr;
            #1;
            checkVal($sformatf("vec%0d_ctl", i), {mem_valid, mem_wr, iBus_cmd_ready, dBus_cmd_ready},
                     {v.mV, v.mWr, v.iR, v.dR});
            checkVal($sformatf("vec%0d_addr_mask", i), {mem_addr, mem_wmask}, {v.mAddr, v.mMask});
            if (v.chkW) checkVal($sformatf("vec%0d_wdata", i), mem_wdata, v.mWdata);
            if (v.mr && v.mV && !v.mWr) finishRead(v.dV, i);
        end

        // Fetch at 0x10, data one cycle after accept.
        @(negedge clk);
        idleInputs();
        driveI(32'h10);
        mem_ready = 1'b1;
        #1;
        checkVal("fetch_accept", {iBus_cmd_ready, mem_addr}, {1'b1, 15'h4});
        @(negedge clk);
        idleInputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0013;
        #1;
        checkVal("fetch_wait_state", {dbgState, iBus_rsp_valid}, {WAIT_I, 1'b0});
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checkVal("fetch_rsp", {iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst},
                 {1'b1, 1'b0, 32'h13});
        @(negedge clk);
        #1;
        checkVal("fetch_rsp_one_cycle", iBus_rsp_valid, 1'b0);

        // Both buses request reads together.
        @(negedge clk);
        idleInputs();
        driveD(1'b0, 32'h30, 32'h0, 2'd2);
        driveI(32'h40);
        mem_ready = 1'b1;
        #1;
        checkVal("both_first", {dBus_cmd_ready, iBus_cmd_ready}, 2'b10);
        @(negedge clk);
        dBus_cmd_valid = 1'b0;
        #1;
        checkVal("both_wait1", {iBus_cmd_ready, mem_valid}, 2'b00);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55;
        #1;
        checkVal("both_wait2", {iBus_cmd_ready, mem_valid}, 2'b00);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checkVal("both_d_rsp", {dBus_rsp_ready, dBus_rsp_data}, {1'b1, 32'h55});
        checkVal("both_i_granted", {iBus_cmd_ready, mem_addr}, {1'b1, 15'h10});
        @(negedge clk);
        iBus_cmd_valid = 1'b0;
        mem_rvalid     = 1'b1;
        mem_rdata      = 32'h66;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checkVal("both_i_rsp", {iBus_rsp_valid, dBus_rsp_ready, iBus_rsp_payload_inst}, {2'b10, 32'h66});

        // Memory stalls for three cycles, then accepts.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idleInputs();
            driveD(1'b1, 32'h44, 32'h12345678, 2'd2);
            mem_ready = (c == 3);
            #1;
            checkVal($sformatf("stall%0d_ready", c), {mem_valid, dBus_cmd_ready}, {1'b1, c == 3});
            checkVal($sformatf("stall%0d_payload", c), {mem_wr, mem_addr, mem_wdata, mem_wmask},
                     {1'b1, 15'h11, 32'h12345678, 4'hF});
        end
        @(negedge clk);
        idleInputs();
        #1;
        checkVal("write_no_rsp", {dBus_rsp_ready, iBus_rsp_valid}, 2'b00);

        // Read returning an error.
        @(negedge clk);
        driveD(1'b0, 32'h8, 32'h0, 2'd2);
        mem_ready = 1'b1;
        @(negedge clk);
        idleInputs();
        mem_rvalid = 1'b1;
        mem_err    = 1'b1;
        mem_rdata  = 32'hDEAD_0001;
        @(negedge clk);
        idleInputs();
        #1;
        checkVal("err_rsp", {dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data, iBus_rsp_valid},
                 {2'b11, 32'hDEAD_0001, 1'b0});

        // Reset while waiting for read data; the late data must be dropped.
        @(negedge clk);
        driveD(1'b0, 32'h14, 32'h0, 2'd2);
        mem_ready = 1'b1;
        #1;
        checkVal("rstmid_accept", dBus_cmd_ready, 1'b1);
        @(negedge clk);
        idleInputs();
        reset = 1'b1;
        #1;
        checkVal("rstmid_wait_state", dbgState, WAIT_D);
        @(negedge clk);
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD;
        #1;
        checkVal("rstmid_idle", dbgState, IDLE);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        checkVal("rstmid_no_rsp", {dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data}, 34'd0);

`ifdef CPU_MEM_ARB_ADDR_CHECK_EN
        // Out-of-range requests are trapped without touching memory.
        @(negedge clk);
        idleInputs();
        driveD(1'b0, 32'h0002_0000, 32'h0, 2'd2);
        mem_ready = 1'b1;
        #1;
        checkVal("oor_rd_accept", {mem_valid, dBus_cmd_ready}, 2'b01);
        @(negedge clk);
        idleInputs();
        #1;
        checkVal("oor_rd_rsp", {dBus_rsp_ready, dBus_rsp_error, dBus_rsp_data}, {2'b11, 32'h0});
        @(negedge clk);
        driveD(1'b1, 32'h0003_0000, 32'hFFFFFFFF, 2'd2);
        #1;
        checkVal("oor_wr_accept", {mem_valid, mem_wr, dBus_cmd_ready}, 3'b001);
        @(negedge clk);
        idleInputs();
        #1;
        checkVal("oor_wr_silent", dBus_rsp_ready, 1'b0);
        @(negedge clk);
        driveI(32'h0004_0000);
        #1;
        checkVal("oor_fetch_accept", {mem_valid, iBus_cmd_ready}, 2'b01);
        @(negedge clk);
        idleInputs();
        #1;
        checkVal("oor_fetch_rsp", {iBus_rsp_valid, iBus_rsp_payload_error, iBus_rsp_payload_inst},
                 {2'b11, 32'h0});
`endif

        // Random traffic against a word-level memory model.
        for (int w = 0; w < 16; w++) begin
            devMem[w] = $urandom;
            refMem[w] = devMem[w];
        end
        iPend = 1'b0; dPend = 1'b0; dWr = 1'b0; dSize = 2'd0;
        iPc = 32'd0; dAddr = 32'd0; dData = 32'd0;
        busyOwner = 0; strobeOwner = 0; rvLeft = 0;
        busyData = 32'd0; strobeData = 32'd0; strobeErr = 1'b0; devWord = 4'd0;
        @(negedge clk);
        idleInputs();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!iPend && $urandom_range(0, 3) == 0) begin
                iPend = 1'b1;
                iPc   = randAddr() & ~32'h3;
            end
            if (!dPend && $urandom_range(0, 2) == 0) begin
                dPend = 1'b1;
                dWr   = 1'($urandom_range(0, 1));
                dSize = 2'($urandom_range(0, 3));
                dAddr = randAddr();
                dData = replicate($urandom, dSize);
            end
            idleInputs();
            if (dPend) driveD(dWr, dAddr, dData, dSize);
            if (iPend) driveI(iPc);
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rdata = $urandom;
            rvNow     = 1'b0;
            if (rvLeft > 0) begin
                rvLeft--;
                if (rvLeft == 0) begin
                    rvNow      = 1'b1;
                    mem_rvalid = 1'b1;
                    mem_rdata  = devMem[devWord];
                    mem_err    = ($urandom_range(0, 7) == 0);
                end
            end else if (busyOwner == 0 && $urandom_range(0, 9) == 0) begin
                mem_rvalid = 1'b1;
            end
            #1;

            checkVal("rnd_rsp_strobe", {iBus_rsp_valid, dBus_rsp_ready}, {strobeOwner == 1, strobeOwner == 2});
            if (strobeOwner == 1)
                checkVal("rnd_i_rsp", {iBus_rsp_payload_error, iBus_rsp_payload_inst}, {strobeErr, strobeData});
            if (strobeOwner == 2)
                checkVal("rnd_d_rsp", {dBus_rsp_error, dBus_rsp_data}, {strobeErr, strobeData});
            strobeOwner = 0;

            gD = (busyOwner == 0) && dPend;
            gI = (busyOwner == 0) && !dPend && iPend;
            expAddr = gD ? dAddr : (gI ? iPc : 32'd0);
            checkVal("rnd_grant", {mem_valid, iBus_cmd_ready, dBus_cmd_ready, mem_wr},
                     {gD || gI, gI && mem_ready, gD && mem_ready, gD && dWr});
            if (gD || gI)
                checkVal("rnd_payload", {mem_addr, mem_wmask},
                         {expAddr[16:2], refMask(gD && dWr, dSize, dAddr)});
            else
                checkVal("rnd_idle_payload", {mem_addr, mem_wmask, mem_wdata}, 64'd0);
            if (gD && dWr)
                checkVal("rnd_wdata", mem_wdata, dData);

            if (rvNow) begin
                strobeOwner = busyOwner;
                strobeData  = busyData;
                strobeErr   = mem_err;
                busyOwner   = 0;
            end
            if (gI && mem_ready) begin
                iPend     = 1'b0;
                busyOwner = 1;
                busyData  = refMem[iPc[5:2]];
            end
            if (gD && mem_ready) begin
                dPend = 1'b0;
                if (dWr) begin
                    refMem[dAddr[5:2]] = mergeBytes(refMem[dAddr[5:2]], dData, refMask(1'b1, dSize, dAddr));
                end else begin
                    busyOwner = 2;
                    busyData  = refMem[dAddr[5:2]];
                end
            end
            // Memory device responds to whatever the arbiter actually presented.
            if (mem_valid && mem_ready) begin
                if (mem_wr) begin
                    devMem[mem_addr[3:0]] = mergeBytes(devMem[mem_addr[3:0]], mem_wdata, mem_wmask);
                end else begin
                    rvLeft  = $urandom_range(1, 3);
                    devWord = mem_addr[3:0];
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
